csr_counter_ro: RTL and testbench
=================================

Name: csr_counter_ro

Overview:
- Read-only CSR source that drives csr_ro_data for the CSR read/write register file.
- Holds the machine counters mcycle, minstret and time, plus constant ID CSRs: misa, mvendorid, marchid, mimpid, mhartid.
- Combinational read port, addressed by csr_ro_addr; all counters are sequential.
- Sits directly upstream of the CSR register file; that file falls back to csr_ro_data for any address it does not own.

Parameters:
- HART_ID, 32'h0, value returned for mhartid.
- MISA_VAL, 32'h40000100, value returned for misa (RV32I).
- VENDOR_ID, 32'h0, value returned for mvendorid; marchid and mimpid also return 0.
- TIME_DIV, 16, clock cycles per time tick; legal range 1..65535.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- csr_ro_addr  input  12  CSR address to read.
- csr_ro_data  output  32  read data for csr_ro_addr; combinational.
- instr_retire  input  1  one pulse per retired instruction, sampled each clock.
- count_inhibit  input  3  mcountinhibit image: bit0 = CY, bit1 = TM (ignored), bit2 = IR.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset:
  - mcycle, minstret, time, time prescaler all clear to 0 immediately on reset_n low, independent of clock.
  - Reset mid-count discards all counts; counting resumes on the first rising edge after reset_n goes high.
  - csr_ro_data has no reset value of its own; during reset it is the decode of csr_ro_addr against the cleared counters, so counter reads return 0.
- mcycle (64 bit): +1 every clock while count_inhibit[0]==0; holds otherwise.
- minstret (64 bit): +1 on a clock where instr_retire==1 and count_inhibit[2]==0; at most +1 per clock.
- time (64 bit):
  - Prescaler counts 0..TIME_DIV-1 every clock, never inhibited.
  - time increments on the clock where the prescaler wraps from TIME_DIV-1 to 0.
  - TIME_DIV==1: time increments every clock.
- All counters wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag. The carry into the high word is part of the same single-cycle 64-bit add; no extra cycle.
- Read decode, zero latency:
  - 12'hB00 / 12'hB80: mcycle[31:0] / [63:32].
  - 12'hB02 / 12'hB82: minstret[31:0] / [63:32].
  - 12'h301: MISA_VAL.
  - 12'hF11: VENDOR_ID. 12'hF12, 12'hF13: 0. 12'hF14: HART_ID.
  - Any other address: 32'h0.
- Read value is the registered counter value before the current cycle's increment. A read in the same cycle as an increment returns the old value.
- Split 64-bit reads are not atomic. Software uses the high/low/high retry sequence; no hardware latch.
- Writes to counters are not supported by this block. Write attempts are handled, or ignored, by the CSR register file.

Optional Feature:
- Macro CSR_USER_COUNTER_EN.
- Defined:
  - User aliases decode: 12'hC00/12'hC80 = mcycle low/high; 12'hC01/12'hC81 = time low/high; 12'hC02/12'hC82 = minstret low/high.
  - time counter and prescaler are instantiated.
- Undefined:
  - Those six addresses read 32'h0.
  - time counter and prescaler are not built.
  - Machine counter behaviour is identical in both builds.

Decomposition:
- Shared package csr_pkg holds:
  - 12-bit CSR address constants for every address above, plus MSTATUS, MIE, MTVEC, MSCRATCH, MEPC, MCAUSE, MTVAL, MIP.
  - Default MISA value.
  - Counter width constant (64).
- One sub-module, csr_counter64:
  - 64-bit counter with ports clock, reset_n, inc_en, value[63:0].
  - Instantiated for mcycle, minstret and time.
  - Prescaler and read mux stay in csr_counter_ro.

Test Plan:
- Reset, then 10 clocks with inhibit=0 -> read 12'hB00 = 10, 12'hB80 = 0, 12'hB02 = 0.
- instr_retire high for 5 of 8 clocks with count_inhibit=3'b100 on 2 of those 5 -> 12'hB02 = 3; mcycle = 8.
- Carry test:
  - Force mcycle to 64'h0000_0000_FFFF_FFFE via reset and clocks, or backdoor -> after 2 clocks 12'hB00 = 0 and 12'hB80 = 1.
  - Force 64'hFFFF_FFFF_FFFF_FFFF -> after 1 clock both words = 0.
- TIME_DIV=4, CSR_USER_COUNTER_EN defined, 17 clocks after reset -> 12'hC01 = 4; 12'hC00 equals 12'hB00.
- Assert reset_n low asynchronously mid-cycle after 100 clocks -> 12'hB00 reads 0 before the next edge. Reads of 12'hF14, 12'h301, 12'h7C0 -> HART_ID, MISA_VAL, 0.
- CSR_USER_COUNTER_EN undefined -> reads of 12'hC00, 12'hC01, 12'hC82 all return 0 while 12'hB00 is non-zero.

Source files
------------

// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared CSR definitions for the counter / ID block and the CSR register file:
//   - 12-bit CSR address constants (machine counters, user counter aliases,
//     ID registers and the trap-handling CSRs owned by the register file)
//   - default MISA value (RV32I) and the counter width
//   - csr_half(): selects the low or high 32-bit word of a 64-bit counter
// ---------------------------------------------------------------------------
package csr_pkg;

    localparam int unsigned CSR_CNT_W = 64;

    localparam logic [31:0] MISA_DEFAULT = 32'h4000_0100;

    // Machine trap setup / handling (owned by the register file)
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;

    // Machine counters
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // User counter aliases
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // Machine information registers
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Word select for split 64-bit counter reads
    function automatic logic [31:0] csr_half(input logic [CSR_CNT_W-1:0] v,
                                             input logic                 sel_hi);
        logic [31:0] w;
        if (sel_hi) begin
            w = v[63:32];
        end else begin
            w = v[31:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/csr_counter_ro_if.sv
// ---------------------------------------------------------------------------
// csr_counter_ro_if
// Read bus between the CSR register file (master) and the read-only counter /
// ID source (slave).
//   csr_ro_addr  master -> slave  12-bit CSR address
//   csr_ro_data  slave  -> master 32-bit read data, combinational
// ---------------------------------------------------------------------------
interface csr_counter_ro_if;

    logic [11:0] csr_ro_addr;
    logic [31:0] csr_ro_data;

    modport master (
        output csr_ro_addr,
        input  csr_ro_data
    );

    modport slave (
        input  csr_ro_addr,
        output csr_ro_data
    );

endinterface

// File: rtl/csr_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64
// Free-running 64-bit counter with enable; wraps to 0 with no flag. The carry
// into the upper word is part of the same single-cycle add.
//   clock    system clock
//   reset_n  asynchronous active-low reset, clears the count
//   inc_en   count +1 on this rising edge
//   value    registered count
// ---------------------------------------------------------------------------
module csr_counter64
    import csr_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 inc_en,
    output logic [CSR_CNT_W-1:0] value
);

    logic [CSR_CNT_W-1:0] r_value;

    // Count register: +1 when enabled, otherwise hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= 64'd0;
        end else if (inc_en) begin
            r_value <= r_value + 64'd1;
        end else begin
            r_value <= r_value;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/csr_counter_ro.sv
// ---------------------------------------------------------------------------
// csr_counter_ro
// Read-only CSR source: mcycle, minstret, (optional) time, and constant ID
// registers, decoded combinationally onto csr_ro_data. Reads see the
// registered counter value, i.e. before the current cycle's increment.
//
// Build option: define CSR_USER_COUNTER_EN to build the time prescaler and
// counter and to decode the user aliases cycle/time/instret (C00..C82).
// Without it those addresses read 0 and no time logic exists.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   bus            csr_counter_ro_if.slave (csr_ro_addr in, csr_ro_data out)
//   instr_retire   one pulse per retired instruction
//   count_inhibit  mcountinhibit image: [0] CY, [1] TM (ignored), [2] IR
// ---------------------------------------------------------------------------
module csr_counter_ro
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = MISA_DEFAULT,
    parameter logic [31:0] VENDOR_ID = 32'h0000_0000,
    parameter int unsigned TIME_DIV  = 16
)(
    input  logic                   clock,
    input  logic                   reset_n,
    csr_counter_ro_if.slave        bus,
    input  logic                   instr_retire,
    input  logic [2:0]             count_inhibit
);

    logic [CSR_CNT_W-1:0] w_mcycle;
    logic [CSR_CNT_W-1:0] w_minstret;
    logic                 w_cy_inc;
    logic                 w_ir_inc;
    logic [31:0]          w_rd_data;
    logic                 w_unused_tm;

    assign w_cy_inc    = ~count_inhibit[0];
    assign w_ir_inc    = instr_retire & ~count_inhibit[2];
    // time is never inhibited, so the TM bit has no effect
    assign w_unused_tm = count_inhibit[1];

    csr_counter64 u_mcycle (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_en  (w_cy_inc),
        .value   (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_en  (w_ir_inc),
        .value   (w_minstret)
    );

`ifdef CSR_USER_COUNTER_EN
    localparam logic [15:0] PRESC_LAST = 16'(TIME_DIV - 1);

    logic [15:0]          r_presc;
    logic                 w_presc_wrap;
    logic [CSR_CNT_W-1:0] w_time;

    // With TIME_DIV == 1 PRESC_LAST is 0, so the wrap fires every clock
    assign w_presc_wrap = (r_presc == PRESC_LAST);

    // Time prescaler: 0..TIME_DIV-1, free running
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= 16'd0;
        end else if (w_presc_wrap) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    csr_counter64 u_time (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_en  (w_presc_wrap),
        .value   (w_time)
    );
`else
    localparam int unsigned unused_time_div = TIME_DIV;
`endif

    // Read decode, zero latency; unknown addresses read 0
    always_comb begin
        w_rd_data = 32'h0000_0000;
        case (bus.csr_ro_addr)
            CSR_MCYCLE:    w_rd_data = csr_half(w_mcycle, 1'b0);
            CSR_MCYCLEH:   w_rd_data = csr_half(w_mcycle, 1'b1);
            CSR_MINSTRET:  w_rd_data = csr_half(w_minstret, 1'b0);
            CSR_MINSTRETH: w_rd_data = csr_half(w_minstret, 1'b1);
            CSR_MISA:      w_rd_data = MISA_VAL;
            CSR_MVENDORID: w_rd_data = VENDOR_ID;
            CSR_MARCHID:   w_rd_data = 32'h0000_0000;
            CSR_MIMPID:    w_rd_data = 32'h0000_0000;
            CSR_MHARTID:   w_rd_data = HART_ID;
`ifdef CSR_USER_COUNTER_EN
            CSR_CYCLE:     w_rd_data = csr_half(w_mcycle, 1'b0);
            CSR_CYCLEH:    w_rd_data = csr_half(w_mcycle, 1'b1);
            CSR_TIME:      w_rd_data = csr_half(w_time, 1'b0);
            CSR_TIMEH:     w_rd_data = csr_half(w_time, 1'b1);
            CSR_INSTRET:   w_rd_data = csr_half(w_minstret, 1'b0);
            CSR_INSTRETH:  w_rd_data = csr_half(w_minstret, 1'b1);
`endif
            default:       w_rd_data = 32'h0000_0000;
        endcase
    end

    assign bus.csr_ro_data = w_rd_data;

endmodule

// File: tb/tb_csr_counter_ro.sv
// ---------------------------------------------------------------------------
// tb_csr_counter_ro
// Directed and randomized stimulus for csr_counter_ro against a reference
// model that counts events with plain 64-bit integers; time is derived as
// (clock edges since reset) / TIME_DIV.
// ---------------------------------------------------------------------------
module tb_csr_counter_ro;

    localparam logic [31:0] P_HART   = 32'h0000_0005;
    localparam logic [31:0] P_MISA   = 32'h4000_0100;
    localparam logic [31:0] P_VENDOR = 32'h0000_0A5A;
    localparam int unsigned P_TDIV   = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       instr_retire = 1'b0;
    logic [2:0] count_inhibit = 3'b000;

    csr_counter_ro_if ifc ();

    csr_counter_ro #(
        .HART_ID   (P_HART),
        .MISA_VAL  (P_MISA),
        .VENDOR_ID (P_VENDOR),
        .TIME_DIV  (P_TDIV)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (ifc),
        .instr_retire  (instr_retire),
        .count_inhibit (count_inhibit)
    );

    always #25 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    longint unsigned m_cyc   = 0;
    longint unsigned m_ret   = 0;
    longint unsigned m_edges = 0;

    function automatic logic [31:0] exp_rd(input logic [11:0] a);
        logic [63:0] c;
        logic [63:0] r;
        logic [63:0] t;
        logic [31:0] v;
        c = m_cyc;
        r = m_ret;
        t = m_edges / 64'(P_TDIV);
        case (a)
            12'hB00: v = c[31:0];
            12'hB80: v = c[63:32];
            12'hB02: v = r[31:0];
            12'hB82: v = r[63:32];
            12'h301: v = P_MISA;
            12'hF11: v = P_VENDOR;
            12'hF14: v = P_HART;
`ifdef CSR_USER_COUNTER_EN
            12'hC00: v = c[31:0];
            12'hC80: v = c[63:32];
            12'hC01: v = t[31:0];
            12'hC81: v = t[63:32];
            12'hC02: v = r[31:0];
            12'hC82: v = r[63:32];
`endif
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic check_rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        ifc.csr_ro_addr = a;
        #1;
        n_checks++;
        assert (ifc.csr_ro_data === exp) else begin
            n_fails++;
            $error("FAIL %s addr=%h observed=%h expected=%h", tag, a, ifc.csr_ro_data, exp);
        end
    endtask

    task automatic check_model(input logic [11:0] a, input string tag);
        check_rd(a, exp_rd(a), tag);
    endtask

    // One rising edge with the currently driven inputs; returns at the negedge
    task automatic tick();
        @(posedge clock);
        if (!count_inhibit[0]) m_cyc++;
        if (instr_retire && !count_inhibit[2]) m_ret++;
        m_edges++;
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Short asynchronous reset pulse between clock edges
    task automatic pulse_reset();
        reset_n = 1'b0;
        m_cyc = 0;
        m_ret = 0;
        m_edges = 0;
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [11:0] addrs [16];
        bit   [7:0]  ret_pat;
        bit   [7:0]  inh_pat;
        addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC01, 12'hC81,
                  12'hC02, 12'hC82, 12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0};
        ifc.csr_ro_addr = 12'h000;

        // Reads while held in reset
        @(negedge clock);
        check_rd(12'hB00, 32'h0, "rst_mcycle");
        check_rd(12'hB80, 32'h0, "rst_mcycleh");
        check_rd(12'hB02, 32'h0, "rst_minstret");
        check_rd(12'hF14, P_HART, "rst_hartid");
        check_rd(12'h301, P_MISA, "rst_misa");
        check_rd(12'hF11, P_VENDOR, "rst_vendor");
        check_rd(12'hF12, 32'h0, "rst_marchid");
        check_rd(12'hF13, 32'h0, "rst_mimpid");
        reset_n = 1'b1;

        // 10 uninhibited clocks, no retires
        ticks(10);
        check_rd(12'hB00, 32'd10, "cyc10_lo");
        check_rd(12'hB80, 32'd0, "cyc10_hi");
        check_rd(12'hB02, 32'd0, "ret10_lo");

        // 5 retires in 8 clocks, IR inhibited on 2 of them
        pulse_reset();
        ret_pat = 8'b0101_1011;
        inh_pat = 8'b0000_1001;
        for (int i = 0; i < 8; i++) begin
            instr_retire  = ret_pat[i];
            count_inhibit = inh_pat[i] ? 3'b100 : 3'b000;
            tick();
        end
        instr_retire  = 1'b0;
        count_inhibit = 3'b000;
        check_rd(12'hB02, 32'd3, "ret_inhibit");
        check_rd(12'hB00, 32'd8, "cyc_8");

        // mcycle inhibit holds the count
        count_inhibit = 3'b001;
        ticks(3);
        count_inhibit = 3'b000;
        check_rd(12'hB00, 32'd8, "cyc_inhibit_hold");

        // Carry into the high word
        force dut.u_mcycle.r_value = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.u_mcycle.r_value;
        m_cyc = 64'h0000_0000_FFFF_FFFE;
        check_rd(12'hB00, 32'hFFFF_FFFE, "carry_pre_lo");
        ticks(2);
        check_rd(12'hB00, 32'h0, "carry_lo");
        check_rd(12'hB80, 32'h1, "carry_hi");

        // Full 64-bit wrap
        force dut.u_mcycle.r_value = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_mcycle.r_value;
        m_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check_rd(12'hB00, 32'h0, "wrap_lo");
        check_rd(12'hB80, 32'h0, "wrap_hi");

        // 17 clocks after reset: time = 17 / 4 = 4
        pulse_reset();
        ticks(17);
        check_rd(12'hB00, 32'd17, "cyc17");
`ifdef CSR_USER_COUNTER_EN
        check_rd(12'hC01, 32'd4, "time17");
        check_rd(12'hC00, 32'd17, "cycle_alias");
        check_rd(12'hC81, 32'd0, "timeh17");
`else
        check_rd(12'hC00, 32'h0, "noalias_c00");
        check_rd(12'hC01, 32'h0, "noalias_c01");
        check_rd(12'hC82, 32'h0, "noalias_c82");
`endif

        // Asynchronous reset mid-cycle after 100 clocks
        pulse_reset();
        instr_retire = 1'b1;
        ticks(100);
        instr_retire = 1'b0;
        check_rd(12'hB00, 32'd100, "cyc100");
        #5;
        reset_n = 1'b0;
        m_cyc = 0;
        m_ret = 0;
        m_edges = 0;
        check_rd(12'hB00, 32'h0, "async_rst_cyc");
        check_rd(12'hB02, 32'h0, "async_rst_ret");
        check_rd(12'hF14, P_HART, "hartid");
        check_rd(12'h301, P_MISA, "misa");
        check_rd(12'h7C0, 32'h0, "unmapped");
        reset_n = 1'b1;
        ticks(3);
        check_rd(12'hB00, 32'd3, "resume_cyc");

        // Randomized traffic checked against the model
        for (int i = 0; i < 400; i++) begin
            instr_retire  = 1'($urandom_range(0, 1));
            count_inhibit = 3'($urandom_range(0, 7));
            tick();
            for (int k = 0; k < 4; k++) begin
                check_model(addrs[$urandom_range(0, 15)], "rand");
            end
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
                check_model(12'hB00, "rand_rst");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
